// File: rtl/leglite_multicycle_control.sv
// LEGLite multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB control strobes,
// memory handshakes with timeout, and a retired-instruction counter.
`timescale 1ns/1ps
module leglite_multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             reg2loc,
    output logic             alusrc,
    output logic [2:0]       alu_select,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op,
    output logic             bus_error
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bus_error_q, bus_error_d;

    logic is_add, is_ld, is_st, is_cbz, is_addi, is_andi, legal;
    logic in_instr;

    assign is_add   = (opcode == 4'd0);
    assign is_ld    = (opcode == 4'd5);
    assign is_st    = (opcode == 4'd6);
    assign is_cbz   = (opcode == 4'd7);
    assign is_addi  = (opcode == 4'd8);
    assign is_andi  = (opcode == 4'd9);
    assign legal    = is_add | is_ld | is_st | is_cbz | is_addi | is_andi;
    assign in_instr = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                      (state_q == S_MEM)    || (state_q == S_WB);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            wait_q      <= 8'd0;
            count_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        bus_error_d = bus_error_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = legal ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (is_cbz)              state_d = S_FETCH;
                else if (is_ld || is_st) state_d = S_MEM;
                else                     state_d = S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = is_ld ? S_WB : S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // Every wait window starts from zero in its new state.
        if (state_d != state_q) wait_d = 8'd0;
    end

    // One pc_write per instruction marks its retirement.
    assign count_d = count_q + CNT_W'(pc_write);

    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel_branch = 1'b0;
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        regwrite      = 1'b0;
        illegal_op    = 1'b0;
        reg2loc       = 1'b0;
        alusrc        = 1'b0;
        alu_select    = 3'd0;
        memtoreg      = 1'b0;
        if (in_instr) begin
            unique case (1'b1)
                is_ld:   begin alusrc = 1'b1; memtoreg = 1'b1; end
                is_st:   begin reg2loc = 1'b1; alusrc = 1'b1; end
                is_cbz:  begin reg2loc = 1'b1; alu_select = 3'd2; end
                is_addi: alusrc = 1'b1;
                is_andi: begin alusrc = 1'b1; alu_select = 3'd4; end
                default: ;
            endcase
        end
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_DECODE: begin
                pc_write   = !legal;
                illegal_op = !legal;
            end
            S_EXEC: begin
                pc_write      = is_cbz;
                pc_sel_branch = is_cbz & zero;
            end
            S_MEM: begin
                dmem_read  = is_ld;
                dmem_write = is_st;
                pc_write   = is_st & dmem_ready;
            end
            S_WB: begin
                regwrite = 1'b1;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            pc_sel_branch = 1'b0;
            dmem_read     = 1'b0;
            dmem_write    = 1'b0;
            regwrite      = 1'b0;
            illegal_op    = 1'b0;
        end
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_leglite_multicycle_control.sv
// Bench for leglite_multicycle_control: per-instruction phase model with
// randomized opcodes, wait states and stray ready inputs.
`timescale 1ns/1ps
module tb_leglite_multicycle_control;

    logic        clock, reset;
    logic [3:0]  opcode;
    logic        zero, imem_ready, dmem_ready;
    logic        imem_req, ir_write, pc_write, pc_sel_branch;
    logic        reg2loc, alusrc, dmem_read, dmem_write, memtoreg;
    logic        regwrite, illegal_op, bus_error;
    logic [2:0]  alu_select, state;
    logic [15:0] instr_count;

    logic        w_imem_req, w_ir_write, w_pc_write, w_pc_sel;
    logic        w_reg2loc, w_alusrc, w_dmem_read, w_dmem_write;
    logic        w_memtoreg, w_regwrite, w_illegal_op, w_bus_error;
    logic [2:0]  w_alu_select, w_state;
    logic [3:0]  w_instr_count;

    leglite_multicycle_control dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_sel_branch(pc_sel_branch), .reg2loc(reg2loc),
        .alusrc(alusrc), .alu_select(alu_select),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .memtoreg(memtoreg), .regwrite(regwrite), .state(state),
        .instr_count(instr_count), .illegal_op(illegal_op),
        .bus_error(bus_error)
    );

    // Narrow counter copy so wrap-around is reachable in a short run.
    leglite_multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(4)) u_wrap (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(w_imem_req), .ir_write(w_ir_write),
        .pc_write(w_pc_write), .pc_sel_branch(w_pc_sel),
        .reg2loc(w_reg2loc), .alusrc(w_alusrc),
        .alu_select(w_alu_select), .dmem_read(w_dmem_read),
        .dmem_write(w_dmem_write), .memtoreg(w_memtoreg),
        .regwrite(w_regwrite), .state(w_state),
        .instr_count(w_instr_count), .illegal_op(w_illegal_op),
        .bus_error(w_bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [7:0] B_IREQ = 8'h80, B_IRW = 8'h40, B_PCW = 8'h20;
    localparam logic [7:0] B_PSEL = 8'h10, B_DR  = 8'h08, B_DW  = 8'h04;
    localparam logic [7:0] B_RW   = 8'h02, B_ILL = 8'h01;
    localparam logic [17:0] FULL  = 18'h3FFFF;
    localparam logic [17:0] NOSEL = 18'h3FF81;

    typedef struct {
        int op;
        bit z;
        int iw;
        int dw;
    } instr_t;

    typedef struct {
        logic [17:0] v;
        logic [17:0] m;
        bit          pi, vi, pd, vd;
    } exp_t;

    int passed = 0;
    int total  = 0;
    int exp_count = 0;

    function automatic logic [17:0] row(input logic [2:0] st,
                                        input logic [7:0] stb,
                                        input logic m2r,
                                        input logic [4:0] sel,
                                        input logic be);
        return {st, stb, m2r, sel, be};
    endfunction

    function automatic logic [17:0] obs();
        return {state, imem_req, ir_write, pc_write, pc_sel_branch,
                dmem_read, dmem_write, regwrite, illegal_op, memtoreg,
                reg2loc, alusrc, alu_select, bus_error};
    endfunction

    // {reg2loc, alusrc, alu_select} for each legal opcode.
    function automatic logic [4:0] sel_of(input int op);
        case (op)
            5:       return {1'b0, 1'b1, 3'd0};
            6:       return {1'b1, 1'b1, 3'd0};
            7:       return {1'b1, 1'b0, 3'd2};
            8:       return {1'b0, 1'b1, 3'd0};
            9:       return {1'b0, 1'b1, 3'd4};
            default: return 5'd0;
        endcase
    endfunction

    task automatic run_instr(input instr_t it);
        exp_t        q[$];
        logic [17:0] o;
        logic [4:0]  s;
        bit legal, ld, st, cbz;
        legal = it.op inside {0, 5, 6, 7, 8, 9};
        ld    = (it.op == 5);
        st    = (it.op == 6);
        cbz   = (it.op == 7);
        s     = legal ? sel_of(it.op) : 5'd0;
        for (int i = 0; i < it.iw; i++)
            q.push_back('{row(0, B_IREQ, 0, 0, 0), FULL, 1, 0, 0, 0});
        q.push_back('{row(0, B_IREQ | B_IRW, 0, 0, 0), FULL, 1, 1, 0, 0});
        if (!legal) begin
            q.push_back('{row(1, B_PCW | B_ILL, 0, 0, 0), NOSEL, 0, 0, 0, 0});
        end else begin
            q.push_back('{row(1, 8'h00, ld, s, 0), FULL, 0, 0, 0, 0});
            q.push_back('{row(2, (cbz ? B_PCW : 8'h00) |
                              ((cbz && it.z) ? B_PSEL : 8'h00), ld, s, 0),
                          FULL, 0, 0, 0, 0});
            if (ld || st) begin
                for (int i = 0; i < it.dw; i++)
                    q.push_back('{row(3, ld ? B_DR : B_DW, ld, s, 0),
                                  FULL, 0, 0, 1, 0});
                q.push_back('{row(3, ld ? B_DR : (B_DW | B_PCW), ld, s, 0),
                              FULL, 0, 0, 1, 1});
            end
            if (!cbz && !st)
                q.push_back('{row(4, B_RW | B_PCW, ld, s, 0),
                              FULL, 0, 0, 0, 0});
        end
        foreach (q[k]) begin
            imem_ready = q[k].pi ? q[k].vi : 1'($urandom);
            dmem_ready = q[k].pd ? q[k].vd : 1'($urandom);
            opcode     = (k < it.iw) ? 4'($urandom) : 4'(it.op);
            zero       = (k <= it.iw) ? 1'($urandom) : it.z;
            @(negedge clock);
            o = obs();
            total++;
            if ((o & q[k].m) !== (q[k].v & q[k].m))
                $display("FAIL step op=%0d k=%0d got=%h want=%h",
                         it.op, k, o & q[k].m, q[k].v & q[k].m);
            else passed++;
            @(posedge clock); #1;
        end
        exp_count++;
        total++;
        if (instr_count !== 16'(exp_count))
            $display("FAIL instr_count got=%h want=%h",
                     instr_count, 16'(exp_count));
        else passed++;
        total++;
        if (w_instr_count !== 4'(exp_count))
            $display("FAIL instr_count_w4 got=%h want=%h",
                     w_instr_count, 4'(exp_count));
        else passed++;
    endtask

    task automatic test_reset();
        logic [17:0] o;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            opcode     = 4'($urandom);
            zero       = 1'($urandom);
            @(negedge clock);
            o = obs();
            total++;
            if (o[14:7] !== 8'h00)
                $display("FAIL reset_strobes got=%h want=00", o[14:7]);
            else passed++;
            @(posedge clock); #1;
        end
        total++;
        if ({state, bus_error, instr_count} !== {3'd0, 1'b0, 16'd0})
            $display("FAIL reset_state got=%0d/%0d/%h want=0/0/0000",
                     state, bus_error, instr_count);
        else passed++;
        reset = 1'b1;
        exp_count = 0;
    endtask

    task automatic test_directed();
        instr_t d[$];
        d = '{'{0, 0, 0, 0}, '{5, 0, 0, 3}, '{6, 0, 0, 0}, '{7, 1, 0, 0},
              '{7, 0, 0, 0}, '{3, 0, 0, 0}, '{8, 1, 1, 0}, '{9, 0, 2, 0}};
        foreach (d[i]) run_instr(d[i]);
    endtask

    task automatic test_random(input int n);
        int legal_ops[6] = '{0, 5, 6, 7, 8, 9};
        instr_t it;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                it.op = legal_ops[$urandom_range(0, 5)];
            end else begin
                it.op = 0;
                while (it.op inside {0, 5, 6, 7, 8, 9})
                    it.op = int'($urandom_range(0, 15));
            end
            it.z  = 1'($urandom);
            it.iw = int'($urandom_range(0, 4));
            it.dw = int'($urandom_range(0, 4));
            run_instr(it);
        end
    endtask

    task automatic test_reset_mid_st();
        logic [17:0] o;
        opcode = 4'd6; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++;
        if (state !== 3'd3)
            $display("FAIL st_in_mem got=%0d want=3", state);
        else passed++;
        reset = 1'b0; dmem_ready = 1'b1;
        @(negedge clock);
        o = obs();
        total++;
        if (o[14:7] !== 8'h00)
            $display("FAIL st_reset_strobes got=%h want=00", o[14:7]);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b1; dmem_ready = 1'b0;
        exp_count = 0;
        total++;
        if ({state, instr_count} !== {3'd0, 16'd0})
            $display("FAIL st_reset_after got=%0d/%h want=0/0000",
                     state, instr_count);
        else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) run_instr('{12, 0, 0, 0});
        run_instr('{0, 0, 0, 0});
        total++;
        if ({w_instr_count, instr_count} !== {4'h0, 16'h0010})
            $display("FAIL wrap got=%h/%h want=0/0010",
                     w_instr_count, instr_count);
        else passed++;
    endtask

    task automatic check_halt_then_reset(input string tag);
        logic [17:0] o;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom);
            dmem_ready = 1'($urandom);
            opcode     = 4'($urandom);
            @(negedge clock);
            o = obs();
            total++;
            if (o !== row(7, 8'h00, 0, 0, 1))
                $display("FAIL %s_halt got=%h want=%h",
                         tag, o, row(7, 8'h00, 0, 0, 1));
            else passed++;
            @(posedge clock); #1;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_count = 0;
        total++;
        if ({state, bus_error, instr_count} !== {3'd0, 1'b0, 16'd0})
            $display("FAIL %s_recover got=%0d/%0d/%h want=0/0/0000",
                     tag, state, bus_error, instr_count);
        else passed++;
    endtask

    task automatic test_fetch_timeout();
        for (int i = 0; i < 15; i++) begin
            imem_ready = 1'b0;
            dmem_ready = 1'($urandom);
            @(negedge clock);
            total++;
            if ({state, imem_req, bus_error} !== {3'd0, 1'b1, 1'b0})
                $display("FAIL fetch_wait i=%0d got=%0d/%0d/%0d want=0/1/0",
                         i, state, imem_req, bus_error);
            else passed++;
            @(posedge clock); #1;
        end
        check_halt_then_reset("fetch_to");
    endtask

    task automatic test_mem_timeout();
        opcode = 4'd5; imem_ready = 1'b1; dmem_ready = 1'b0;
        @(posedge clock); #1;
        imem_ready = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        for (int i = 0; i < 15; i++) begin
            dmem_ready = 1'b0;
            imem_ready = 1'($urandom);
            @(negedge clock);
            total++;
            if ({state, dmem_read, bus_error} !== {3'd3, 1'b1, 1'b0})
                $display("FAIL mem_wait i=%0d got=%0d/%0d/%0d want=3/1/0",
                         i, state, dmem_read, bus_error);
            else passed++;
            @(posedge clock); #1;
        end
        check_halt_then_reset("mem_to");
    endtask

    initial begin
        opcode = 4'd0; zero = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        reset = 1'b0;
        test_reset();
        test_directed();
        test_random(40);
        test_reset_mid_st();
        test_wrap();
        test_fetch_timeout();
        test_mem_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/leglite_multicycle_control.md
Name: leglite_multicycle_control

Overview:
Multicycle sequencer for the LEGLite core. It replaces the single-cycle decode with a FETCH/DECODE/EXEC/MEM/WB state machine that steps the shared datapath through each instruction. It drives the per-phase control strobes, handshakes with instruction and data memories, and keeps a retired-instruction counter. It sits between the IR and opcode field and the datapath muxes, ALU, register file, PC and memories.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before a bus error (1..255).
CNT_W, 16, width of the retired-instruction counter.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset.
opcode  in  4  IR opcode field: 0 ADD, 5 LD, 6 ST, 7 CBZ, 8 ADDI, 9 ANDI; all others illegal.
zero  in  1  ALU zero flag, valid in EXEC.
imem_ready  in  1  instruction memory data valid.
dmem_ready  in  1  data memory access complete.
imem_req  out  1  instruction fetch request.
ir_write  out  1  load IR.
pc_write  out  1  update PC.
pc_sel_branch  out  1  1 = PC takes branch target, 0 = PC+1.
reg2loc  out  1  register-file read port 2 select.
alusrc  out  1  ALU operand B = immediate.
alu_select  out  3  ALU op: 0 add, 2 pass/compare-zero, 4 and.
dmem_read  out  1  data memory read strobe.
dmem_write  out  1  data memory write strobe.
memtoreg  out  1  write-back source = memory.
regwrite  out  1  register-file write enable.
state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 HALT.
instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.
illegal_op  out  1  one-cycle pulse when an illegal opcode is retired.
bus_error  out  1  sticky; memory timeout occurred.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state goes to FETCH; wait counter, instr_count and bus_error clear to 0.
  - While reset=0, every strobe output is forced to 0: imem_req, ir_write, pc_write, pc_sel_branch, dmem_read, dmem_write, regwrite, illegal_op.
  - Reset mid-instruction abandons the instruction. No write strobe is issued in the cycle reset is low.
- Output timing: all strobes are combinational from the registered state, opcode and ready inputs (Mealy on ready only). Mux selects (reg2loc, alusrc, alu_select, memtoreg) hold their opcode values in DECODE through WB. They are 0 in FETCH and HALT.
- Opcode use: the IR changes only on ir_write, so opcode is stable from DECODE until the next FETCH.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_write=1 and go to DECODE.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, set bus_error and go to HALT.
- DECODE: register read.
  - Legal opcode: go to EXEC.
  - Illegal opcode: pc_write=1, pc_sel_branch=0, illegal_op=1, instr_count+1, go to FETCH (treated as a NOP).
- EXEC:
  - CBZ: pc_write=1, pc_sel_branch=zero, instr_count+1, go to FETCH.
  - LD and ST: go to MEM.
  - ADD, ADDI and ANDI: go to WB.
- MEM:
  - LD: dmem_read=1. ST: dmem_write=1.
  - The strobe is held until dmem_ready=1.
  - On dmem_ready=1, LD goes to WB. ST asserts pc_write=1 (sel 0), instr_count+1, and goes to FETCH.
  - Timeout rule is the same as FETCH, using the wait counter.
- WB:
  - regwrite=1, memtoreg=1 for LD (0 otherwise), pc_write=1 (sel 0), instr_count+1, go to FETCH.
- Wait counter: clears on every state change. It counts only in FETCH and MEM while ready=0.
- HALT: all strobes 0. State holds until reset. bus_error stays 1.
- Per-opcode selects:
  - ADD: reg2loc 0, alusrc 0, alu 0.
  - LD: 0/1/0.
  - ST: reg2loc 1, alusrc 1, alu 0.
  - CBZ: reg2loc 1, alusrc 0, alu 2.
  - ADDI: 0/1/0.
  - ANDI: 0/1/4.
- Latency with zero-wait memory: CBZ 3, ADD/ADDI/ANDI 4, ST 4, LD 5, illegal 2 cycles.
- Exactly one pc_write per instruction. regwrite and dmem_write are never both 1.
- instr_count wraps from all-ones to 0 without a flag.
- A ready input asserted in a state that does not wait on it is ignored.

Test Plan:
1. Reset released, imem_ready=1, opcode=0 (ADD): states FETCH→DECODE→EXEC→WB; WB has regwrite=1, memtoreg=0, pc_write=1; instr_count=1 after cycle 4.
2. LD (5) with dmem_ready delayed 3 cycles: dmem_read=1 for 4 cycles, then WB with regwrite=1, memtoreg=1; ST (6) with immediate ready: dmem_write=1 one cycle, pc_write in MEM, regwrite never 1.
3. CBZ (7): with zero=1, EXEC gives pc_write=1, pc_sel_branch=1; with zero=0, pc_sel_branch=0; each takes 3 cycles with alu_select=2, reg2loc=1.
4. opcode=3 (illegal): DECODE gives illegal_op=1 for one cycle and pc_write=1, return to FETCH after 2 cycles; regwrite, dmem_read and dmem_write stay 0.
5. imem_ready held 0 for 15 cycles (MEM_TIMEOUT=15): bus_error=1, state=7, all strobes 0 until reset; reset=0 for one cycle returns to FETCH with bus_error=0.
6. Reset=0 asserted during MEM of an ST with dmem_ready=1 the same cycle: dmem_write=0 that cycle, state=FETCH next cycle; preload instr_count=0xFFFF, then retire ADD → 0x0000.
